letter_writer: RTL and testbench

//  Transmit end of the 2-bit letter symbol stream: takes one letter code per handshake and

---
 rtl/letter_pkg.sv | 27 ++
 rtl/letter_rom.sv | 46 ++++
 rtl/letter_writer.sv | 156 +++++++++++++++
 tb/tb_letter_writer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/letter_pkg.sv
// Shared constants for the 2-bit letter symbol stream: letter codes, symbols,
// maximum letter length and the writer FSM state encoding.
package letter_pkg;

    localparam logic [1:0] LTR_I    = 2'd0;
    localparam logic [1:0] LTR_H    = 2'd1;
    localparam logic [1:0] LTR_W    = 2'd2;
    localparam logic [1:0] LTR_RSVD = 2'd3;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_01   = 2'b01;
    localparam logic [1:0] SYM_10   = 2'b10;
    localparam logic [1:0] SYM_11   = 2'b11;

    localparam int MAX_LEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic is_reserved(input logic [1:0] code);
        return (code == LTR_RSVD);
    endfunction

endpackage

// File: rtl/letter_rom.sv
// Combinational symbol table: letter code and symbol index to symbol, plus the
// number of non-zero symbols in the letter. Out-of-range indices return SYM_IDLE.
module letter_rom
    import letter_pkg::*;
(
    input  logic [1:0] i_code,
    input  logic [1:0] i_idx,
    output logic [1:0] o_sym,
    output logic [1:0] o_len
);

    // Symbol and length lookup
    always_comb begin
        o_sym = SYM_IDLE;
        o_len = 2'd0;
        case (i_code)
            LTR_I: begin
                o_len = 2'd1;
                if (i_idx == 2'd0) o_sym = SYM_11;
                else               o_sym = SYM_IDLE;
            end
            LTR_H: begin
                o_len = 2'd2;
                case (i_idx)
                    2'd0:    o_sym = SYM_11;
                    2'd1:    o_sym = SYM_01;
                    default: o_sym = SYM_IDLE;
                endcase
            end
            LTR_W: begin
                o_len = 2'd3;
                case (i_idx)
                    2'd0:    o_sym = SYM_10;
                    2'd1:    o_sym = SYM_10;
                    2'd2:    o_sym = SYM_01;
                    default: o_sym = SYM_IDLE;
                endcase
            end
            default: begin
                o_len = 2'd0;
                o_sym = SYM_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/letter_writer.sv
// Letter writer: accepts one letter code per valid/ready handshake and drives its
// symbol sequence on bits followed by GAP_CYCLES of 00. Macro LETTER_WRITER_ERR_EN adds err.
module letter_writer
    import letter_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       restart,
    input  logic [1:0] letter,
    input  logic       valid,
    output logic       ready,
    output logic [1:0] bits,
    output logic       busy,
    output logic       done
`ifdef LETTER_WRITER_ERR_EN
   ,output logic       err
`endif
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    state_t        r_state;
    logic [1:0]    r_code;
    logic [1:0]    r_idx;
    logic [GW-1:0] r_gap;
    logic [1:0]    r_bits;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;

    state_t        w_state_nxt;
    logic [1:0]    w_code_nxt;
    logic [1:0]    w_idx_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [1:0]    w_bits_nxt;
    logic          w_done_nxt;
    logic          w_accept;
    logic [1:0]    w_idx_inc;
    logic [GW-1:0] w_gap_inc;
    logic [1:0]    w_rom_code;
    logic [1:0]    w_rom_idx;
    logic [1:0]    w_rom_sym;
    logic [1:0]    w_rom_len;

    assign w_accept  = valid && (r_state == ST_IDLE) && !is_reserved(letter);
    assign w_idx_inc = r_idx + 2'd1;
    assign w_gap_inc = r_gap + GW'(1'b1);

    // In IDLE the table looks ahead at the incoming letter so symbol 0 lands on the accept edge
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_rom_code = letter;
            w_rom_idx  = 2'd0;
        end else begin
            w_rom_code = r_code;
            w_rom_idx  = w_idx_inc;
        end
    end

    letter_rom u_rom (
        .i_code (w_rom_code),
        .i_idx  (w_rom_idx),
        .o_sym  (w_rom_sym),
        .o_len  (w_rom_len)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_bits_nxt  = SYM_IDLE;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                    w_code_nxt  = letter;
                    w_idx_nxt   = 2'd0;
                    w_bits_nxt  = w_rom_sym;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_idx_inc >= w_rom_len) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GW'(1'b1);
                    w_done_nxt  = (GAP_CYCLES == 1);
                end else begin
                    w_idx_nxt  = w_idx_inc;
                    w_bits_nxt = w_rom_sym;
                end
            end
            ST_GAP: begin
                if (r_gap >= GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt  = w_gap_inc;
                    w_done_nxt = (w_gap_inc == GAP_LAST);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (restart) begin
            r_state <= ST_IDLE;
            r_code  <= LTR_I;
            r_idx   <= 2'd0;
            r_gap   <= '0;
            r_bits  <= SYM_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_bits  <= w_bits_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign ready = r_ready;
    assign bits  = r_bits;
    assign busy  = r_busy;
    assign done  = r_done;

`ifdef LETTER_WRITER_ERR_EN
    logic r_err;

    // Reserved code is consumed in IDLE and flagged one cycle later
    always_ff @(posedge clk) begin
        if (restart) begin
            r_err <= 1'b0;
        end else begin
            r_err <= valid && (r_state == ST_IDLE) && is_reserved(letter);
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_letter_writer.sv
// Directed, table-driven bench for letter_writer (GAP_CYCLES=1) plus a hand-written
// GAP_CYCLES=3 sequence on a second instance.
module tb_letter_writer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       restart, valid, ready, busy, done;
    logic [1:0] letter, bits;
    logic       restart3, valid3, ready3, busy3, done3;
    logic [1:0] letter3, bits3;
`ifdef LETTER_WRITER_ERR_EN
    logic       err, err3;
`endif

    letter_writer #(.GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .restart(restart), .letter(letter), .valid(valid),
        .ready(ready), .bits(bits), .busy(busy), .done(done)
`ifdef LETTER_WRITER_ERR_EN
       ,.err(err)
`endif
    );

    letter_writer #(.GAP_CYCLES(3)) u_dut3 (
        .clk(clk), .restart(restart3), .letter(letter3), .valid(valid3),
        .ready(ready3), .bits(bits3), .busy(busy3), .done(done3)
`ifdef LETTER_WRITER_ERR_EN
       ,.err(err3)
`endif
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] ltr;
        logic [1:0] e_bits;
        logic       e_ready;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [1:0] l, input logic [1:0] eb,
                       input logic er, input logic ebz, input logic ed, input logic ee);
        vec_t t;
        t = '{rst: r, vld: v, ltr: l, e_bits: eb, e_ready: er, e_busy: ebz, e_done: ed, e_err: ee};
        vecs.push_back(t);
    endtask

    initial begin
        logic [1:0] exp3_bits [0:5];
        logic       exp3_done [0:5];
        logic       exp3_busy [0:5];

        restart = 1'b1; valid = 1'b0; letter = 2'd0;
        restart3 = 1'b1; valid3 = 1'b0; letter3 = 2'd0;

        // restart dominates valid
        add(1'b1, 1'b1, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        // single I
        add(1'b0, 1'b1, 2'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        // W then H with valid held; letter switches to H while W is busy
        add(1'b0, 1'b1, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'd1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        // restart during the second W symbol, then a clean I
        add(1'b0, 1'b1, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'd2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        // reserved code: never emits, err only when the option is built in
        add(1'b0, 1'b1, 2'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 2'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            restart = vecs[i].rst;
            valid   = vecs[i].vld;
            letter  = vecs[i].ltr;
            @(posedge clk); #1;
            check("bits",  i, bits,          vecs[i].e_bits);
            check("ready", i, {1'b0, ready}, {1'b0, vecs[i].e_ready});
            check("busy",  i, {1'b0, busy},  {1'b0, vecs[i].e_busy});
            check("done",  i, {1'b0, done},  {1'b0, vecs[i].e_done});
`ifdef LETTER_WRITER_ERR_EN
            check("err",   i, {1'b0, err},   {1'b0, vecs[i].e_err});
`endif
        end

        // GAP_CYCLES=3, send H: 11,01,00,00,00 with done only on the third 00
        exp3_bits[0] = 2'b11; exp3_done[0] = 1'b0; exp3_busy[0] = 1'b1;
        exp3_bits[1] = 2'b01; exp3_done[1] = 1'b0; exp3_busy[1] = 1'b1;
        exp3_bits[2] = 2'b00; exp3_done[2] = 1'b0; exp3_busy[2] = 1'b1;
        exp3_bits[3] = 2'b00; exp3_done[3] = 1'b0; exp3_busy[3] = 1'b1;
        exp3_bits[4] = 2'b00; exp3_done[4] = 1'b1; exp3_busy[4] = 1'b1;
        exp3_bits[5] = 2'b00; exp3_done[5] = 1'b0; exp3_busy[5] = 1'b0;
        @(posedge clk); #1;
        restart3 = 1'b0; valid3 = 1'b1; letter3 = 2'd1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            valid3 = 1'b0;
            check("gap3_bits", k, bits3,          exp3_bits[k]);
            check("gap3_done", k, {1'b0, done3},  {1'b0, exp3_done[k]});
            check("gap3_busy", k, {1'b0, busy3},  {1'b0, exp3_busy[k]});
        end
        check("gap3_ready", 6, {1'b0, ready3}, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
